branch_tagged_issue_queue: RTL and testbench

BRANCH_TAGGED_ISSUE_QUEUE -- requirements
Module: branch_tagged_issue_queue

---
 rtl/issue_q_pkg.sv | 33 +++
 rtl/branch_tagged_issue_queue_br_tag_alloc.sv | 69 ++++++
 rtl/branch_tagged_issue_queue.sv | 199 +++++++++++++++++++
 tb/tb_branch_tagged_issue_queue.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/issue_q_pkg.sv
// Shared definitions for the branch-tagged issue queue: parameter defaults,
// the stored entry layout and the branch-tag age helper.
// No ports (package).
package issue_q_pkg;

    localparam int DEPTH_DEF = 16;
    localparam int IN_W_DEF  = 2;
    localparam int OUT_W_DEF = 4;
    localparam int NBR_DEF   = 8;
    localparam int REG_W_DEF = 4;
    localparam int OP_W_DEF  = 4;
    localparam int IME_W_DEF = 5;
    localparam int BR_W_DEF  = $clog2(NBR_DEF);

    typedef struct packed {
        logic [REG_W_DEF-1:0] des;
        logic [REG_W_DEF-1:0] s1;
        logic [REG_W_DEF-1:0] s2;
        logic [OP_W_DEF-1:0]  op;
        logic [IME_W_DEF-1:0] ime;
        logic [BR_W_DEF-1:0]  tag;
        logic                 is_br;
        logic                 spec;
    } entry_t;

    // Distance of a tag from the oldest outstanding tag; the power-of-two
    // tag space makes the natural wrap of the subtraction the modulo.
    function automatic logic [BR_W_DEF-1:0] tag_age(input logic [BR_W_DEF-1:0] tag,
                                                    input logic [BR_W_DEF-1:0] head);
        return tag - head;
    endfunction

endpackage

// File: rtl/branch_tagged_issue_queue_br_tag_alloc.sv
// br_tag_alloc: owns the circular branch-tag window (br_head, br_tail,
// outstanding). Handles allocation of up to IN_W tags per cycle, in-order
// resolve of the oldest tag and flush rewind of br_tail.
// Ports: clk, rst (async, active high); alloc_cnt tags taken this cycle;
// resolve_en/resolve_id; flush_en/flush_id; br_tail, outstanding, free_tags,
// branch_full status; resolve_ok/flush_ok qualified events; br_head_res
// (head after this cycle's resolve) and flush_age (flush_id age against it).
module br_tag_alloc
    import issue_q_pkg::*;
#(
    parameter int NBR  = NBR_DEF,
    parameter int IN_W = IN_W_DEF,
    localparam int BR_W = $clog2(NBR),
    localparam int OC_W = $clog2(NBR + 1),
    localparam int AC_W = $clog2(IN_W + 1)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [AC_W-1:0] alloc_cnt,
    input  logic            resolve_en,
    input  logic [BR_W-1:0] resolve_id,
    input  logic            flush_en,
    input  logic [BR_W-1:0] flush_id,
    output logic [BR_W-1:0] br_tail,
    output logic [OC_W-1:0] outstanding,
    output logic [OC_W-1:0] free_tags,
    output logic            branch_full,
    output logic            resolve_ok,
    output logic            flush_ok,
    output logic [BR_W-1:0] br_head_res,
    output logic [BR_W-1:0] flush_age
);

    logic [BR_W-1:0] br_head_q;
    logic [BR_W-1:0] br_tail_q;
    logic [OC_W-1:0] outs_q;
    logic [OC_W-1:0] outs_res;

    // Resolve is applied before flush, so the flush is judged against the
    // window as it stands after the resolve.
    assign resolve_ok  = resolve_en && (outs_q != '0) && (resolve_id == br_head_q);
    assign br_head_res = br_head_q + BR_W'(resolve_ok);
    assign outs_res    = outs_q - OC_W'(resolve_ok);
    assign flush_age   = tag_age(flush_id, br_head_res);
    assign flush_ok    = flush_en && (OC_W'(flush_age) < outs_res);

    assign br_tail     = br_tail_q;
    assign outstanding = outs_q;
    assign free_tags   = OC_W'(NBR) - outs_q;
    assign branch_full = (outs_q == OC_W'(NBR));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            br_head_q <= '0;
            br_tail_q <= '0;
            outs_q    <= '0;
        end else begin
            br_head_q <= br_head_res;
            if (flush_ok) begin
                br_tail_q <= flush_id + BR_W'(1);
                outs_q    <= OC_W'(flush_age) + OC_W'(1);
            end else begin
                br_tail_q <= br_tail_q + BR_W'(alloc_cnt);
                outs_q    <= outs_res + OC_W'(alloc_cnt);
            end
        end
    end

endmodule

// File: rtl/branch_tagged_issue_queue.sv
// branch_tagged_issue_queue: in-order circular issue queue whose entries carry
// the tag of the youngest outstanding branch, so a mispredict can drop the
// speculative suffix and a correct resolve can clear speculation.
// Ports: clk, rst (async, active high); in_* enqueue lanes with in_rdy
// per-lane accept; out_take pop count; flush_en/flush_id mispredict;
// br_resolve_en/br_resolve_id correct resolve; out_* zero-latency view of the
// OUT_W oldest entries; entry_full, entry_empty, branch_full, count status.
module branch_tagged_issue_queue
    import issue_q_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int IN_W  = IN_W_DEF,
    parameter int OUT_W = OUT_W_DEF,
    parameter int NBR   = NBR_DEF,
    parameter int REG_W = REG_W_DEF,
    parameter int OP_W  = OP_W_DEF,
    parameter int IME_W = IME_W_DEF,
    localparam int BR_W  = $clog2(NBR),
    localparam int TK_W  = $clog2(OUT_W + 1),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [IN_W-1:0]             in_vld,
    input  logic [IN_W-1:0]             in_is_br,
    input  logic [IN_W-1:0][REG_W-1:0]  in_des,
    input  logic [IN_W-1:0][REG_W-1:0]  in_s1,
    input  logic [IN_W-1:0][REG_W-1:0]  in_s2,
    input  logic [IN_W-1:0][OP_W-1:0]   in_op,
    input  logic [IN_W-1:0][IME_W-1:0]  in_ime,
    output logic [IN_W-1:0]             in_rdy,
    input  logic [TK_W-1:0]             out_take,
    input  logic                        flush_en,
    input  logic [BR_W-1:0]             flush_id,
    input  logic                        br_resolve_en,
    input  logic [BR_W-1:0]             br_resolve_id,
    output logic [OUT_W-1:0]            out_vld,
    output logic [OUT_W-1:0][REG_W-1:0] out_des,
    output logic [OUT_W-1:0][REG_W-1:0] out_s1,
    output logic [OUT_W-1:0][REG_W-1:0] out_s2,
    output logic [OUT_W-1:0][OP_W-1:0]  out_op,
    output logic [OUT_W-1:0][IME_W-1:0] out_ime,
    output logic [OUT_W-1:0][BR_W-1:0]  out_branch,
    output logic                        entry_full,
    output logic                        entry_empty,
    output logic                        branch_full,
    output logic [CNT_W-1:0]            count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int OC_W  = $clog2(NBR + 1);
    localparam int AC_W  = $clog2(IN_W + 1);

    entry_t           ent_q [DEPTH];
    logic [PTR_W-1:0] head, tail, head_p;
    logic [CNT_W-1:0] count_q, count_p, free_slots, take_ext, pop, keep;
    logic [IN_W-1:0]  accept;
    entry_t           wr_ent [IN_W];
    logic [AC_W-1:0]  n_acc, n_br;

    logic [BR_W-1:0]  br_tail, br_head_res, flush_age;
    logic [OC_W-1:0]  outstanding, free_tags;
    logic             resolve_ok, flush_ok;

    br_tag_alloc #(.NBR(NBR), .IN_W(IN_W)) u_br (
        .clk         (clk),
        .rst         (rst),
        .alloc_cnt   (n_br),
        .resolve_en  (br_resolve_en),
        .resolve_id  (br_resolve_id),
        .flush_en    (flush_en),
        .flush_id    (flush_id),
        .br_tail     (br_tail),
        .outstanding (outstanding),
        .free_tags   (free_tags),
        .branch_full (branch_full),
        .resolve_ok  (resolve_ok),
        .flush_ok    (flush_ok),
        .br_head_res (br_head_res),
        .flush_age   (flush_age)
    );

    // Free space is taken before this cycle's pop: no pop-to-enqueue bypass.
    assign free_slots  = CNT_W'(DEPTH) - count_q;
    assign take_ext    = CNT_W'(out_take);
    assign pop         = (take_ext > count_q) ? count_q : take_ext;
    assign count_p     = count_q - pop;
    assign head_p      = head + PTR_W'(pop);
    assign entry_full  = (count_q == CNT_W'(DEPTH));
    assign entry_empty = (count_q == '0);
    assign count       = count_q;
    assign in_rdy      = accept;

    // Lane acceptance and tag assignment. A branch in a lower lane becomes
    // the youngest branch for higher lanes in the same cycle.
    always_comb begin
        logic            ok;
        logic            have;
        logic [BR_W-1:0] last_tag;
        ok       = !flush_en && !rst;
        have     = (outstanding != '0);
        last_tag = br_tail - BR_W'(1);
        n_acc    = '0;
        n_br     = '0;
        accept   = '0;
        for (int i = 0; i < IN_W; i++) begin
            wr_ent[i] = '0;
            if (ok && in_vld[i] && (CNT_W'(i) < free_slots) &&
                (!in_is_br[i] || (OC_W'(n_br) < free_tags))) begin
                accept[i]       = 1'b1;
                wr_ent[i].des   = in_des[i];
                wr_ent[i].s1    = in_s1[i];
                wr_ent[i].s2    = in_s2[i];
                wr_ent[i].op    = in_op[i];
                wr_ent[i].ime   = in_ime[i];
                wr_ent[i].is_br = in_is_br[i];
                if (in_is_br[i]) begin
                    last_tag = br_tail + BR_W'(n_br);
                    have     = 1'b1;
                    n_br     = n_br + AC_W'(1);
                end
                wr_ent[i].tag  = have ? last_tag : '0;
                // A same-cycle resolve of the tag just inherited must not
                // leave the new entry speculative on a freed tag.
                wr_ent[i].spec = have && !(resolve_ok && last_tag == br_resolve_id);
                n_acc = n_acc + AC_W'(1);
            end else begin
                ok = 1'b0;
            end
        end
    end

    // Flush: the first surviving-after-pop entry that is removed marks the
    // new tail, since removed entries always form a suffix.
    always_comb begin
        logic             found;
        logic [PTR_W-1:0] idx;
        entry_t           e;
        found = 1'b0;
        keep  = count_p;
        idx   = '0;
        e     = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = head_p + PTR_W'(k);
            e   = ent_q[idx];
            if (!found && (CNT_W'(k) < count_p) && e.spec &&
                !(resolve_ok && e.tag == br_resolve_id) &&
                (tag_age(e.tag, br_head_res) >= flush_age) &&
                !(e.is_br && e.tag == flush_id)) begin
                found = 1'b1;
                keep  = CNT_W'(k);
            end
        end
    end

    // Only spec bits are reset; payload fields keep whatever they held.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head    <= '0;
            tail    <= '0;
            count_q <= '0;
            for (int j = 0; j < DEPTH; j++) begin
                ent_q[j].spec <= 1'b0;
            end
        end else begin
            for (int j = 0; j < DEPTH; j++) begin
                if (resolve_ok && ent_q[j].tag == br_resolve_id) begin
                    ent_q[j].spec <= 1'b0;
                end
            end
            head <= head_p;
            if (flush_ok) begin
                tail    <= head_p + PTR_W'(keep);
                count_q <= keep;
            end else begin
                tail    <= tail + PTR_W'(n_acc);
                count_q <= count_p + CNT_W'(n_acc);
                for (int i = 0; i < IN_W; i++) begin
                    if (accept[i]) begin
                        ent_q[tail + PTR_W'(i)] <= wr_ent[i];
                    end
                end
            end
        end
    end

    always_comb begin
        for (int k = 0; k < OUT_W; k++) begin
            out_vld[k]    = (CNT_W'(k) < count_q);
            out_des[k]    = ent_q[head + PTR_W'(k)].des;
            out_s1[k]     = ent_q[head + PTR_W'(k)].s1;
            out_s2[k]     = ent_q[head + PTR_W'(k)].s2;
            out_op[k]     = ent_q[head + PTR_W'(k)].op;
            out_ime[k]    = ent_q[head + PTR_W'(k)].ime;
            out_branch[k] = ent_q[head + PTR_W'(k)].tag;
        end
    end

endmodule

// File: tb/tb_branch_tagged_issue_queue.sv
module tb_branch_tagged_issue_queue;

    localparam int DEPTH = 16;
    localparam int NBR   = 8;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [1:0]      in_vld, in_is_br, in_rdy;
    logic [1:0][3:0] in_des, in_s1, in_s2, in_op;
    logic [1:0][4:0] in_ime;
    logic [2:0]      out_take;
    logic            flush_en, br_resolve_en;
    logic [2:0]      flush_id, br_resolve_id;
    logic [3:0]      out_vld;
    logic [3:0][3:0] out_des, out_s1, out_s2, out_op;
    logic [3:0][4:0] out_ime;
    logic [3:0][2:0] out_branch;
    logic            entry_full, entry_empty, branch_full;
    logic [4:0]      count;

    branch_tagged_issue_queue dut (
        .clk(clk), .rst(rst),
        .in_vld(in_vld), .in_is_br(in_is_br),
        .in_des(in_des), .in_s1(in_s1), .in_s2(in_s2), .in_op(in_op), .in_ime(in_ime),
        .in_rdy(in_rdy), .out_take(out_take),
        .flush_en(flush_en), .flush_id(flush_id),
        .br_resolve_en(br_resolve_en), .br_resolve_id(br_resolve_id),
        .out_vld(out_vld), .out_des(out_des), .out_s1(out_s1), .out_s2(out_s2),
        .out_op(out_op), .out_ime(out_ime), .out_branch(out_branch),
        .entry_full(entry_full), .entry_empty(entry_empty),
        .branch_full(branch_full), .count(count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int seq    = 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Model: queue of entries oldest-first, list of outstanding tags
    // oldest-first, and the next tag to hand out.
    typedef struct {
        logic [3:0] des, s1, s2, op;
        logic [4:0] ime;
        int         tag;
        bit         is_br;
        bit         spec;
    } ment_t;

    ment_t mq[$];
    int    mbr[$];
    int    mtail = 0;

    always @(negedge clk) begin : cmp
        int         free, nb, npop, p, idx;
        bit         ok, rm;
        logic [1:0] exp_rdy;
        ment_t      e;
        ment_t      nq[$];
        if (rst) begin
            mq.delete();
            mbr.delete();
            mtail = 0;
            chk("rst_count", 32'(count), 0);
            chk("rst_empty", 32'(entry_empty), 1);
            chk("rst_full", 32'(entry_full), 0);
            chk("rst_bfull", 32'(branch_full), 0);
            chk("rst_rdy", 32'(in_rdy), 0);
            chk("rst_vld", 32'(out_vld), 0);
        end else begin
            free = DEPTH - mq.size();
            ok = !flush_en;
            nb = 0;
            exp_rdy = 2'b00;
            for (int i = 0; i < 2; i++) begin
                if (ok && in_vld[i] && i < free && (!in_is_br[i] || nb < NBR - mbr.size())) begin
                    exp_rdy[i] = 1'b1;
                    nb += int'(in_is_br[i]);
                end else begin
                    ok = 0;
                end
            end
            chk("in_rdy", 32'(in_rdy), 32'(exp_rdy));
            chk("count", 32'(count), mq.size());
            chk("entry_full", 32'(entry_full), 32'(mq.size() == DEPTH));
            chk("entry_empty", 32'(entry_empty), 32'(mq.size() == 0));
            chk("branch_full", 32'(branch_full), 32'(mbr.size() == NBR));
            chk("outstanding", 32'(dut.u_br.outs_q), mbr.size());
            chk("br_tail", 32'(dut.u_br.br_tail_q), mtail);
            chk("br_head", 32'(dut.u_br.br_head_q), (mbr.size() > 0) ? mbr[0] : mtail);
            for (int k = 0; k < 4; k++) begin
                chk("out_vld", 32'(out_vld[k]), 32'(k < mq.size()));
                if (k < mq.size()) begin
                    chk("out_des", 32'(out_des[k]), 32'(mq[k].des));
                    chk("out_s1", 32'(out_s1[k]), 32'(mq[k].s1));
                    chk("out_s2", 32'(out_s2[k]), 32'(mq[k].s2));
                    chk("out_op", 32'(out_op[k]), 32'(mq[k].op));
                    chk("out_ime", 32'(out_ime[k]), 32'(mq[k].ime));
                    chk("out_branch", 32'(out_branch[k]), mq[k].tag);
                end
            end
            for (int k = 0; k < mq.size(); k++) begin
                idx = (int'(dut.head) + k) % DEPTH;
                chk("spec", 32'(dut.ent_q[idx].spec), 32'(mq[k].spec));
            end

            npop = (int'(out_take) > mq.size()) ? mq.size() : int'(out_take);
            for (int i = 0; i < 2; i++) begin
                if (exp_rdy[i]) begin
                    e.des = in_des[i]; e.s1 = in_s1[i]; e.s2 = in_s2[i];
                    e.op = in_op[i]; e.ime = in_ime[i]; e.is_br = in_is_br[i];
                    if (in_is_br[i]) begin
                        e.tag = mtail;
                        e.spec = 1;
                        mbr.push_back(mtail);
                        mtail = (mtail + 1) % NBR;
                    end else begin
                        e.tag = (mbr.size() > 0) ? mbr[$] : 0;
                        e.spec = (mbr.size() > 0);
                    end
                    mq.push_back(e);
                end
            end
            repeat (npop) void'(mq.pop_front());
            if (br_resolve_en && mbr.size() > 0 && mbr[0] == int'(br_resolve_id)) begin
                foreach (mq[j]) if (mq[j].spec && mq[j].tag == int'(br_resolve_id)) mq[j].spec = 0;
                void'(mbr.pop_front());
            end
            if (flush_en) begin
                p = -1;
                foreach (mbr[j]) if (mbr[j] == int'(flush_id)) p = j;
                if (p >= 0) begin
                    nq.delete();
                    foreach (mq[j]) begin
                        rm = 0;
                        if (mq[j].spec && !(mq[j].is_br && mq[j].tag == int'(flush_id)))
                            foreach (mbr[t]) if (t >= p && mbr[t] == mq[j].tag) rm = 1;
                        if (!rm) nq.push_back(mq[j]);
                    end
                    mq = nq;
                    while (mbr.size() > p + 1) void'(mbr.pop_back());
                    mtail = (int'(flush_id) + 1) % NBR;
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        in_vld = '0; in_is_br = '0;
        in_des = '0; in_s1 = '0; in_s2 = '0; in_op = '0; in_ime = '0;
        out_take = '0; flush_en = 1'b0; flush_id = '0;
        br_resolve_en = 1'b0; br_resolve_id = '0;
    endtask

    task automatic lane(input int i, input bit br);
        in_vld[i]   = 1'b1;
        in_is_br[i] = br;
        in_des[i]   = 4'(seq);
        in_s1[i]    = 4'(seq + 1);
        in_s2[i]    = 4'(seq + 2);
        in_op[i]    = 4'(seq * 3);
        in_ime[i]   = 5'(seq * 7);
        seq++;
    endtask

    task automatic do_reset();
        clear_in();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
    endtask

    int         s0;
    logic [3:0] exp_d;

    initial begin
        clear_in();
        rst = 1'b1;
        repeat (2) cyc();
        chk("reset_count", 32'(count), 0);
        chk("reset_empty", 32'(entry_empty), 1);
        rst = 1'b0;

        // Fill with two non-branches per cycle.
        for (int c = 0; c < 8; c++) begin
            clear_in(); lane(0, 0); lane(1, 0); cyc();
        end
        #1;
        chk("fill_count", 32'(count), 16);
        chk("fill_full", 32'(entry_full), 1);
        chk("fill_rdy", 32'(in_rdy), 2'b00);
        clear_in();
        // Pop and enqueue while full: space is counted before the pop.
        out_take = 3'd2; lane(0, 0); lane(1, 0);
        #1 chk("full_pop_rdy", 32'(in_rdy), 2'b00);
        cyc();
        chk("full_pop_count", 32'(count), 14);
        clear_in(); lane(0, 0); lane(1, 0);
        #1 chk("refill_rdy", 32'(in_rdy), 2'b11);
        cyc();
        clear_in(); out_take = 3'd4;
        repeat (4) cyc();
        clear_in();
        chk("drain_empty", 32'(entry_empty), 1);

        // Branch plus dependent non-branch, then resolve.
        do_reset();
        lane(0, 1); lane(1, 0); cyc(); clear_in();
        #1;
        chk("br_tag0", 32'(out_branch[0]), 0);
        chk("nb_tag0", 32'(out_branch[1]), 0);
        chk("br_spec", 32'(dut.ent_q[0].spec), 1);
        chk("nb_spec", 32'(dut.ent_q[1].spec), 1);
        chk("outs_1", 32'(dut.u_br.outs_q), 1);
        br_resolve_en = 1'b1; br_resolve_id = 3'd0; cyc(); clear_in();
        #1;
        chk("br_spec_res", 32'(dut.ent_q[0].spec), 0);
        chk("nb_spec_res", 32'(dut.ent_q[1].spec), 0);
        chk("outs_0", 32'(dut.u_br.outs_q), 0);

        // B0 X B1 Y Z, flush 0.
        do_reset();
        lane(0, 1); lane(1, 0); cyc(); clear_in();
        lane(0, 1); lane(1, 0); cyc(); clear_in();
        lane(0, 0); cyc(); clear_in();
        chk("pre_flush_count", 32'(count), 5);
        flush_en = 1'b1; flush_id = 3'd0; cyc(); clear_in();
        chk("flush_count", 32'(count), 1);
        chk("flush_tail", 32'(dut.tail), 32'((int'(dut.head) + 1) % DEPTH));
        chk("flush_br_tail", 32'(dut.u_br.br_tail_q), 1);
        chk("flush_vld", 32'(out_vld), 4'b0001);
        flush_en = 1'b1; flush_id = 3'd5; cyc(); clear_in();
        chk("flush_ignored", 32'(count), 1);
        br_resolve_en = 1'b1; br_resolve_id = 3'd0; flush_en = 1'b1; flush_id = 3'd0;
        cyc(); clear_in();
        chk("res_flush_count", 32'(count), 1);
        chk("res_flush_outs", 32'(dut.u_br.outs_q), 0);

        // Branch tag exhaustion.
        do_reset();
        for (int c = 0; c < 4; c++) begin
            clear_in(); lane(0, 1); lane(1, 1); cyc();
        end
        clear_in(); lane(0, 1);
        #1;
        chk("bfull", 32'(branch_full), 1);
        chk("bfull_rdy", 32'(in_rdy), 2'b00);
        cyc(); clear_in();
        br_resolve_en = 1'b1; br_resolve_id = 3'd0; cyc(); clear_in();
        lane(0, 1); lane(1, 1);
        #1 chk("seven_rdy", 32'(in_rdy), 2'b01);
        cyc(); clear_in();
        chk("wrap_tag", 32'(dut.ent_q[8].tag), 0);
        chk("wrap_bfull", 32'(branch_full), 1);
        flush_en = 1'b1; flush_id = 3'd3; cyc(); clear_in();
        chk("wrap_flush_count", 32'(count), 4);
        chk("wrap_flush_outs", 32'(dut.u_br.outs_q), 3);

        // Over-pop.
        do_reset();
        lane(0, 0); lane(1, 0); cyc(); clear_in();
        lane(0, 0); cyc(); clear_in();
        chk("three_count", 32'(count), 3);
        chk("three_vld", 32'(out_vld), 4'b0111);
        out_take = 3'd4; cyc(); clear_in();
        chk("overpop_vld", 32'(out_vld), 4'b0000);
        chk("overpop_empty", 32'(entry_empty), 1);

        // Mixed traffic driven from the model's view of outstanding tags.
        do_reset();
        for (int c = 0; c < 300; c++) begin
            clear_in();
            if ($urandom_range(0, 3) != 0) begin
                lane(0, $urandom_range(0, 2) == 0);
                if ($urandom_range(0, 1) == 1) lane(1, $urandom_range(0, 2) == 0);
            end
            out_take = 3'($urandom_range(0, 4) * $urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0) begin
                br_resolve_en = 1'b1;
                br_resolve_id = (mbr.size() > 0 && $urandom_range(0, 3) != 0) ? 3'(mbr[0]) : 3'($urandom_range(0, 7));
            end
            if ($urandom_range(0, 11) == 0) begin
                flush_en = 1'b1;
                flush_id = (mbr.size() > 0) ? 3'(mbr[$urandom_range(0, mbr.size() - 1)]) : 3'($urandom_range(0, 7));
            end
            cyc();
        end

        // Asynchronous reset in the middle of a burst with a flush pending.
        do_reset();
        for (int c = 0; c < 3; c++) begin
            clear_in(); lane(0, 0); lane(1, 1); cyc();
        end
        flush_en = 1'b1; flush_id = 3'd1;
        #2 rst = 1'b1;
        #1;
        chk("async_count", 32'(count), 0);
        chk("async_empty", 32'(entry_empty), 1);
        chk("async_full", 32'(entry_full), 0);
        chk("async_bfull", 32'(branch_full), 0);
        chk("async_rdy", 32'(in_rdy), 0);
        chk("async_vld", 32'(out_vld), 0);
        cyc();
        rst = 1'b0;
        clear_in();
        s0 = seq;
        exp_d = 4'(s0);
        lane(0, 0); cyc(); clear_in();
        chk("resume_head", 32'(dut.head), 0);
        chk("resume_tail", 32'(dut.tail), 1);
        chk("resume_des", 32'(out_des[0]), 32'(exp_d));
        chk("resume_slot0", 32'(dut.ent_q[0].des), 32'(exp_d));
        cyc();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
